stack_arbiter: RTL and testbench

- Controller that shares one stack instance between N_REQ requesters.
- Arbitrates push/pop requests round-robin and sequences the stack's one-cycle rd/wr strobes.
- Blocks illegal operations using the stack's of/uf flags, returns pop data and a completion ack to the winner, and tracks stack occupancy.
- Sits between requester logic and the stack.

---
 rtl/stack_arbiter_pkg.sv | 24 ++
 rtl/stack_arbiter_rr_picker.sv | 29 ++
 rtl/stack_arbiter.sv | 127 ++++++++++++
 tb/tb_stack_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_arbiter_pkg.sv
// Shared definitions for the stack arbiter: FSM state and operation
// encodings, default word/address widths and a small index-wrap helper.
package stack_arbiter_pkg;

   localparam int DEF_WORD_LEN  = 8;
   localparam int DEF_WORD_SIZE = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_PUSH = 2'd0,
      OP_POP  = 2'd1,
      OP_BAD  = 2'd2
   } op_t;

   function automatic int wrap_idx(input int i, input int n);
      return i % n;
   endfunction

endpackage

// File: rtl/stack_arbiter_rr_picker.sv
// rr_picker: pure combinational round-robin selector.
//   active : request vector, one bit per requester
//   ptr    : highest-priority index for this pick
//   grant  : first active index at or after ptr, wrapping
//   valid  : at least one requester active
module rr_picker
   import stack_arbiter_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  active,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] grant,
   output logic          valid
);

   always_comb begin
      grant = '0;
      valid = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (!valid && active[wrap_idx(int'(ptr) + k, N)]) begin
            valid = 1'b1;
            grant = PW'(wrap_idx(int'(ptr) + k, N));
         end
      end
   end

endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: shares one stack between N_REQ requesters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | pick a winner round-robin, latch its op and push data
//   ST_ISSUE | one cycle: strobe the stack unless refused (of/uf/bad op)
//   ST_ACK   | one cycle: ack[winner], err and rdata valid
//
// Ports:
//   clk, reset        clock, async active-low reset
//   req_push/req_pop  per-requester level requests, held until ack
//   req_wdata         push data, requester i at [i*WORD_LEN +: WORD_LEN]
//   ack, err, rdata   completion pulse, refusal flag, popped word
//   count             stack occupancy 0..2**WORD_SIZE
//   stk_*             stack strobes, write data, top-of-stack and flags
module stack_arbiter
   import stack_arbiter_pkg::*;
#(
   parameter int WORD_LEN  = DEF_WORD_LEN,
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int N_REQ     = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_push,
   input  logic [N_REQ-1:0]          req_pop,
   input  logic [N_REQ*WORD_LEN-1:0] req_wdata,
   output logic [N_REQ-1:0]          ack,
   output logic                      err,
   output logic [WORD_LEN-1:0]       rdata,
   output logic [WORD_SIZE:0]        count,
   output logic                      stk_rd,
   output logic                      stk_wr,
   output logic [WORD_LEN-1:0]       stk_w_data,
   input  logic [WORD_LEN-1:0]       stk_r_data,
   input  logic                      stk_of,
   input  logic                      stk_uf
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_t              state, state_nxt;
   op_t                 op, op_sel;
   logic [PW-1:0]       ptr, win, grant;
   logic                grant_vld;
   logic [N_REQ-1:0]    active;
   logic [WORD_LEN-1:0] wdata_sel;
   logic                push_ok, pop_ok;

   assign active = req_push | req_pop;

   rr_picker #(.N(N_REQ), .PW(PW)) u_pick (
      .active (active),
      .ptr    (ptr),
      .grant  (grant),
      .valid  (grant_vld)
   );

   always_comb begin
      wdata_sel = req_wdata[int'(grant)*WORD_LEN +: WORD_LEN];
      if (req_push[grant] && req_pop[grant]) begin
         op_sel = OP_BAD;
      end else if (req_push[grant]) begin
         op_sel = OP_PUSH;
      end else begin
         op_sel = OP_POP;
      end
   end

   // Strobes follow state directly so a reset in ISSUE drops them at once.
   assign push_ok = (op == OP_PUSH) && !stk_of;
   assign pop_ok  = (op == OP_POP) && !stk_uf;
   assign stk_wr  = (state == ST_ISSUE) && push_ok;
   assign stk_rd  = (state == ST_ISSUE) && pop_ok;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (grant_vld) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_ACK;
         ST_ACK:   state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         op         <= OP_PUSH;
         ptr        <= '0;
         win        <= '0;
         ack        <= '0;
         err        <= 1'b0;
         rdata      <= '0;
         count      <= '0;
         stk_w_data <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (grant_vld) begin
                  win <= grant;
                  op  <= op_sel;
                  ptr <= (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
                  // Only a push presents data, keeping the bus quiet otherwise.
                  if (op_sel == OP_PUSH) stk_w_data <= wdata_sel;
               end
            end
            ST_ISSUE: begin
               stk_w_data <= '0;
               ack        <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
               err        <= !(push_ok || pop_ok);
               rdata      <= pop_ok ? stk_r_data : '0;
               if (push_ok) count <= count + 1'b1;
               else if (pop_ok) count <= count - 1'b1;
            end
            ST_ACK: begin
               ack   <= '0;
               err   <= 1'b0;
               rdata <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

   localparam int WL    = 8;
   localparam int WS    = 4;
   localparam int N     = 2;
   localparam int DEPTH = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req_push = '0;
   logic [N-1:0]    req_pop = '0;
   logic [N*WL-1:0] req_wdata = '0;
   logic [N-1:0]    ack;
   logic            err;
   logic [WL-1:0]   rdata;
   logic [WS:0]     count;
   logic            stk_rd, stk_wr;
   logic [WL-1:0]   stk_w_data;
   logic [WL-1:0]   stk_r_data;
   logic            stk_of, stk_uf;

   int checks = 0;
   int failures = 0;
   int exp_ptr = 0;
   logic [WL-1:0] model_q[$];

   always #5 clk = ~clk;

   stack_arbiter #(.WORD_LEN(WL), .WORD_SIZE(WS), .N_REQ(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_push   (req_push),
      .req_pop    (req_pop),
      .req_wdata  (req_wdata),
      .ack        (ack),
      .err        (err),
      .rdata      (rdata),
      .count      (count),
      .stk_rd     (stk_rd),
      .stk_wr     (stk_wr),
      .stk_w_data (stk_w_data),
      .stk_r_data (stk_r_data),
      .stk_of     (stk_of),
      .stk_uf     (stk_uf)
   );

   // Stack attached to the arbiter, reacting to its strobes.
   logic [WL-1:0] smem [DEPTH];
   logic [4:0]    ssp;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ssp <= '0;
      end else if (stk_wr && !ssp[4]) begin
         smem[ssp[3:0]] <= stk_w_data;
         ssp <= ssp + 5'd1;
      end else if (stk_rd && ssp != 0) begin
         ssp <= ssp - 5'd1;
      end
   end

   assign stk_of     = (ssp == 5'd16);
   assign stk_uf     = (ssp == 5'd0);
   assign stk_r_data = (ssp != 0) ? smem[4'(ssp - 5'd1)] : 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] act);
      for (int k = 0; k < N; k++) begin
         if (act[(exp_ptr + k) % N]) return (exp_ptr + k) % N;
      end
      return -1;
   endfunction

   // One arbitrated operation: apply requests, await the ack, compare with model.
   task automatic txn(input string tag, input logic [N-1:0] pv, input logic [N-1:0] ov,
                      input logic [N*WL-1:0] wd);
      int w, cyc;
      bit is_push, is_pop, exp_err, got, wr_seen, rd_seen, both_seen;
      logic [WL-1:0] din, exp_rd, wseen;
      @(negedge clk);
      req_push = pv; req_pop = ov; req_wdata = wd;
      w = pick(pv | ov);
      exp_ptr = (w + 1) % N;
      din = wd[w*WL +: WL];
      is_push = pv[w] && !ov[w];
      is_pop  = ov[w] && !pv[w];
      exp_err = !((is_push && model_q.size() < DEPTH) || (is_pop && model_q.size() > 0));
      exp_rd = 8'h00;
      if (is_pop && !exp_err) exp_rd = model_q[$];
      got = 0; cyc = 0; wr_seen = 0; rd_seen = 0; both_seen = 0; wseen = 8'h00;
      while (!got && cyc < 10) begin
         @(negedge clk);
         cyc++;
         if (stk_wr) begin wr_seen = 1; wseen = stk_w_data; end
         if (stk_rd) rd_seen = 1;
         if (stk_wr && stk_rd) both_seen = 1;
         if (ack != 0) got = 1;
      end
      check({tag, "_ack_seen"}, 32'(got), 32'd1);
      if (got) begin
         check({tag, "_latency"}, 32'(cyc), 32'd2);
         check({tag, "_ack"}, 32'(ack), 32'd1 << w);
         check({tag, "_err"}, 32'(err), 32'(exp_err));
         check({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
      end
      req_push = '0; req_pop = '0;
      if (!exp_err) begin
         if (is_push) model_q.push_back(din);
         else void'(model_q.pop_back());
      end
      check({tag, "_count"}, 32'(count), 32'(model_q.size()));
      check({tag, "_wr"}, 32'(wr_seen), 32'(is_push && !exp_err));
      check({tag, "_rd"}, 32'(rd_seen), 32'(is_pop && !exp_err));
      if (wr_seen) check({tag, "_wdata"}, 32'(wseen), 32'(din));
      check({tag, "_rd_wr_excl"}, 32'(both_seen), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, cyc, last, nacks;
      logic [WL-1:0] wseen;

      // Reset held with requests pending.
      req_push = 2'b11;
      req_wdata = {8'h77, 8'h05};
      #13;
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_strobes", 32'({stk_rd, stk_wr}), 32'd0);
      #4 reset = 1'b1;

      // First grant after reset must go to requester 0 (push 05).
      txn("single_push", 2'b11, 2'b00, {8'h77, 8'h05});
      txn("pop_05", 2'b00, 2'b01, '0);

      for (int i = 1; i <= 16; i++) txn("fill", 2'b10, 2'b00, {8'(i), 8'h00});
      check("fill_of", 32'(stk_of), 32'd1);
      txn("overflow", 2'b10, 2'b00, {8'h99, 8'h00});
      for (int i = 0; i < 16; i++) txn("lifo_pop", 2'b00, 2'b10, '0);
      txn("underflow", 2'b00, 2'b10, '0);

      // Both requesters hold push continuously.
      @(negedge clk);
      req_push = 2'b11; req_pop = 2'b00; req_wdata = {8'hB0, 8'hA0};
      nacks = 0; cyc = 0; last = -1; wseen = 8'h00;
      while (nacks < 4 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (stk_wr) wseen = stk_w_data;
         if (ack != 0) begin
            w = pick(2'b11);
            exp_ptr = (w + 1) % N;
            check("rr_grant", 32'(ack), 32'd1 << w);
            check("rr_wdata", 32'(wseen), (w == 1) ? 32'hB0 : 32'hA0);
            if (last >= 0) check("rr_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            model_q.push_back((w == 1) ? 8'hB0 : 8'hA0);
            nacks++;
            if (nacks == 4) begin req_push = '0; end
         end
      end
      check("rr_nacks", 32'(nacks), 32'd4);
      check("rr_count", 32'(count), 32'(model_q.size()));

      txn("illegal", 2'b01, 2'b01, {8'h00, 8'h3C});

      for (int i = 0; i < 40; i++) begin
         logic [N-1:0] pv, ov;
         pv = N'($urandom_range(0, 3));
         ov = N'($urandom_range(0, 3));
         if ((pv | ov) == 0) pv = 2'b01;
         txn("rand", pv, ov, N*WL'($urandom));
      end

      // Reset while an operation is in ISSUE.
      @(negedge clk);
      if (model_q.size() < DEPTH) req_push = 2'b01; else req_pop = 2'b01;
      req_wdata = {8'h00, 8'h5A};
      @(negedge clk);
      check("midrst_strobe_before", 32'(stk_wr | stk_rd), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("midrst_strobe_after", 32'({stk_rd, stk_wr}), 32'd0);
      check("midrst_count", 32'(count), 32'd0);
      req_push = '0; req_pop = '0;
      @(negedge clk);
      check("midrst_ack", 32'(ack), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      #2 reset = 1'b1;
      model_q.delete();
      exp_ptr = 0;
      txn("post_reset_push", 2'b10, 2'b00, {8'hC3, 8'h00});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
